// File: rtl/engine_csr_index_generator_pkg.sv
// Shared types for the CSR index generator: configuration, request and FSM state.
package engine_csr_index_generator_pkg;

  localparam int INDEX_W    = 32;
  localparam int ID_W       = 8;
  localparam int META_TAG_W = 16;

  typedef struct packed {
    logic [ID_W-1:0]       id_cu;
    logic [ID_W-1:0]       id_bundle;
    logic [ID_W-1:0]       id_lane;
    logic [ID_W-1:0]       id_engine;
    logic [ID_W-1:0]       id_module;
    logic [META_TAG_W-1:0] tag;
  } CSRIndexMeta;

  typedef struct packed {
    logic [INDEX_W-1:0] index_start;
    logic [INDEX_W-1:0] index_end;
    logic [INDEX_W-1:0] array_size;
    CSRIndexMeta        meta;
  } CSRIndexConfigurationPayload;

  typedef struct packed {
    logic                        valid;
    CSRIndexConfigurationPayload payload;
  } CSRIndexConfiguration;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    CSRIndexMeta        meta;
  } CSRIndexRequestPayload;

  typedef struct packed {
    logic                  valid;
    CSRIndexRequestPayload payload;
  } CSRIndexRequest;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } engine_csr_index_generator_state;

endpackage

// File: rtl/engine_csr_index_generator_counter.sv
// Loadable index register plus remaining down-counter; index wraps modulo 2^INDEX_WIDTH.
module engine_csr_index_counter #(
  parameter int INDEX_WIDTH = 32
) (
  input  logic                   ap_clk,
  input  logic                   areset,
  input  logic                   load,
  input  logic                   step,
  input  logic [INDEX_WIDTH-1:0] index_start,
  input  logic [INDEX_WIDTH-1:0] count,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   last,
  output logic                   zero
);

  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [INDEX_WIDTH-1:0] remaining_q, remaining_d;

  always_comb begin
    index_d     = index_q;
    remaining_d = remaining_q;
    if (load) begin
      index_d     = index_start;
      remaining_d = count;
    end else if (step) begin
      index_d     = index_q + INDEX_WIDTH'(1);
      remaining_d = remaining_q - INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      index_q     <= '0;
      remaining_q <= '0;
    end else begin
      index_q     <= index_d;
      remaining_q <= remaining_d;
    end
  end

  assign index = index_q;
  assign last  = (remaining_q == INDEX_WIDTH'(1));
  assign zero  = (remaining_q == '0);

endmodule

// File: rtl/engine_csr_index_generator.sv
// Expands one CSR index configuration into a stream of consecutive index requests.
// ENGINE_CSR_INDEX_GENERATOR_LAST_EN enables request_last_out; otherwise it is tied low.
module engine_csr_index_generator
  import engine_csr_index_generator_pkg::*;
#(
  parameter int ID_CU       = 0,
  parameter int ID_BUNDLE   = 0,
  parameter int ID_LANE     = 0,
  parameter int ID_ENGINE   = 0,
  parameter int ID_MODULE   = 0,
  parameter int INDEX_WIDTH = 32
) (
  input  logic                 ap_clk,
  input  logic                 areset,
  input  CSRIndexConfiguration configure_engine_in,
  output logic                 configure_engine_ready,
  output CSRIndexRequest       request_out,
  input  logic                 request_ready_in,
  input  logic                 pause_in,
  output logic                 request_last_out,
  output logic                 done_out,
  output logic                 busy_out
);

  engine_csr_index_generator_state state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic [META_TAG_W-1:0] tag_q, tag_d;

  logic                   cnt_load, cnt_step, cnt_last, cnt_zero;
  logic [INDEX_WIDTH-1:0] cnt_index;
  logic                   handshake;

  engine_csr_index_counter #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_counter (
    .ap_clk     (ap_clk),
    .areset     (areset),
    .load       (cnt_load),
    .step       (cnt_step),
    .index_start(configure_engine_in.payload.index_start),
    .count      (configure_engine_in.payload.array_size),
    .index      (cnt_index),
    .last       (cnt_last),
    .zero       (cnt_zero)
  );

  assign handshake = valid_q && request_ready_in;

  // The counter is loaded on acceptance so LOAD can decide on the zero flag.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && configure_engine_in.valid) begin
          cnt_load = 1'b1;
          tag_d    = configure_engine_in.payload.meta.tag;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
          valid_d = !pause_in;
        end
      end
      BUSY: begin
        if (handshake) begin
          cnt_step = 1'b1;
          if (cnt_last) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            valid_d = !pause_in;
          end
        end else if (!valid_q) begin
          valid_d = !pause_in;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      tag_q   <= tag_d;
    end
  end

  assign request_out.valid                   = valid_q;
  assign request_out.payload.index           = cnt_index;
  assign request_out.payload.meta.id_cu      = ID_W'(ID_CU);
  assign request_out.payload.meta.id_bundle  = ID_W'(ID_BUNDLE);
  assign request_out.payload.meta.id_lane    = ID_W'(ID_LANE);
  assign request_out.payload.meta.id_engine  = ID_W'(ID_ENGINE);
  assign request_out.payload.meta.id_module  = ID_W'(ID_MODULE);
  assign request_out.payload.meta.tag        = tag_q;

  assign configure_engine_ready = ready_q;
  assign done_out               = (state_q == DONE);
  assign busy_out               = (state_q != IDLE);

`ifdef ENGINE_CSR_INDEX_GENERATOR_LAST_EN
  assign request_last_out = valid_q && cnt_last;
`else
  assign request_last_out = 1'b0;
`endif

  // Termination is count-based, so index_end and upstream placement IDs are not consumed.
  logic unused_cfg;
  assign unused_cfg = ^{configure_engine_in.payload.index_end,
                        configure_engine_in.payload.meta.id_cu,
                        configure_engine_in.payload.meta.id_bundle,
                        configure_engine_in.payload.meta.id_lane,
                        configure_engine_in.payload.meta.id_engine,
                        configure_engine_in.payload.meta.id_module};

endmodule

// File: tb/tb_engine_csr_index_generator.sv
// Directed bench for engine_csr_index_generator with immediate-assertion checks.
module tb_engine_csr_index_generator;
  import engine_csr_index_generator_pkg::*;

  logic                 ap_clk;
  logic                 areset;
  CSRIndexConfiguration cfg;
  logic                 cfg_ready;
  CSRIndexRequest       req;
  logic                 req_ready;
  logic                 pause;
  logic                 last;
  logic                 done;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  engine_csr_index_generator #(
    .ID_CU(1), .ID_BUNDLE(2), .ID_LANE(3), .ID_ENGINE(4), .ID_MODULE(5),
    .INDEX_WIDTH(32)
  ) dut (
    .ap_clk                (ap_clk),
    .areset                (areset),
    .configure_engine_in   (cfg),
    .configure_engine_ready(cfg_ready),
    .request_out           (req),
    .request_ready_in      (req_ready),
    .pause_in              (pause),
    .request_last_out      (last),
    .done_out              (done),
    .busy_out              (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic exp_last(input logic is_last);
`ifdef ENGINE_CSR_INDEX_GENERATOR_LAST_EN
    return is_last;
`else
    return 1'b0;
`endif
  endfunction

  // Presents a config in an IDLE cycle; returns one step later (LOAD).
  task automatic send_cfg(input logic [31:0] start, input logic [31:0] size, input logic [15:0] tag);
    chk("ready_before_cfg", cfg_ready, 1'b1);
    cfg.valid               = 1'b1;
    cfg.payload.index_start = start;
    cfg.payload.array_size  = size;
    cfg.payload.index_end   = start + size;
    cfg.payload.meta        = '0;
    cfg.payload.meta.tag    = tag;
    step();
    cfg.valid = 1'b0;
    chk("load_busy", busy, 1'b1);
    chk("load_valid", req.valid, 1'b0);
    chk("load_ready", cfg_ready, 1'b0);
  endtask

  task automatic expect_req(input string tag, input logic [31:0] idx, input logic is_last);
    chk({tag, "_valid"}, req.valid, 1'b1);
    chk({tag, "_index"}, req.payload.index, idx);
    chk({tag, "_last"}, last, exp_last(is_last));
  endtask

  task automatic finish_cfg();
    step();
    chk("done_pulse", done, 1'b1);
    chk("done_valid", req.valid, 1'b0);
    step();
    chk("done_clear", done, 1'b0);
    chk("idle_ready", cfg_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic run_full(input logic [31:0] start, input logic [31:0] size, input logic [15:0] tag);
    logic [31:0] e;
    send_cfg(start, size, tag);
    for (int i = 0; i < int'(size); i++) begin
      step();
      e = start + 32'(i);
      expect_req("full", e, i == int'(size) - 1);
      if (i == 0) begin
        chk("meta_tag", req.payload.meta.tag, tag);
        chk("meta_ids", {req.payload.meta.id_cu, req.payload.meta.id_bundle, req.payload.meta.id_lane,
                         req.payload.meta.id_engine, req.payload.meta.id_module}, 40'h0102030405);
      end
    end
    finish_cfg();
  endtask

  initial begin
    areset    = 1'b1;
    cfg       = '0;
    req_ready = 1'b1;
    pause     = 1'b0;
    step();
    step();
    chk("rst_valid", req.valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_ready", cfg_ready, 1'b0);
    areset = 1'b0;
    step();
    chk("post_rst_ready", cfg_ready, 1'b1);

    // Basic burst at full throughput.
    run_full(32'd100, 32'd4, 16'hA1);

    // Back-pressure on the second request.
    send_cfg(32'd100, 32'd4, 16'hB2);
    step(); expect_req("stall_a", 32'd100, 1'b0);
    step(); expect_req("stall_b", 32'd101, 1'b0);
    req_ready = 1'b0;
    repeat (3) begin
      step(); expect_req("stall_hold", 32'd101, 1'b0);
    end
    req_ready = 1'b1;
    step(); expect_req("stall_c", 32'd102, 1'b0);
    step(); expect_req("stall_d", 32'd103, 1'b1);
    finish_cfg();

    // Empty configuration.
    run_full(32'd55, 32'd0, 16'hC3);

    // Index wrap.
    run_full(32'hFFFF_FFFE, 32'd3, 16'hD4);

    // Pause after the second request.
    send_cfg(32'd20, 32'd5, 16'hE5);
    step(); expect_req("pause_a", 32'd20, 1'b0);
    step(); expect_req("pause_b", 32'd21, 1'b0);
    pause = 1'b1;
    repeat (3) begin
      step();
      chk("paused_valid", req.valid, 1'b0);
      chk("paused_busy", busy, 1'b1);
    end
    pause = 1'b0;
    step(); expect_req("pause_c", 32'd22, 1'b0);
    step(); expect_req("pause_d", 32'd23, 1'b0);
    step(); expect_req("pause_e", 32'd24, 1'b1);
    finish_cfg();

    // Reset in the middle of a burst.
    send_cfg(32'd50, 32'd10, 16'hF6);
    step(); expect_req("mid_a", 32'd50, 1'b0);
    step(); expect_req("mid_b", 32'd51, 1'b0);
    areset = 1'b1;
    #1;
    chk("midrst_valid", req.valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    step();
    areset = 1'b0;
    step();
    chk("midrst_ready", cfg_ready, 1'b1);
    run_full(32'd7, 32'd1, 16'h0707);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
